// File: rtl/fpnew_pkg.sv
// Shared FPU types: floating-point format encoding, its width lookup,
// and the IEEE status flag bundle.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   // Unknown encodings report the widest width so they are never boxed.
   function automatic int unsigned fp_width(fp_format_e f);
      case (f)
         FP32:    return 32;
         FP64:    return 64;
         FP16:    return 16;
         FP8:     return 8;
         FP16ALT: return 16;
         default: return 64;
      endcase
   endfunction

endpackage

// File: rtl/fpnew_retire_fifo_mem.sv
// Register array backing the retire buffer: one write port,
// one combinational read port, no reset.
module fpnew_retire_fifo_mem #(
   parameter int unsigned EW    = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [PW-1:0] waddr_i,
   input  logic [EW-1:0] wdata_i,
   input  logic [PW-1:0] raddr_i,
   output logic [EW-1:0] rdata_o
);

   logic [EW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) r_mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fpnew_divsqrt_retire_buffer.sv
// Retire FIFO behind the div/sqrt unit: buffers results, NaN-boxes
// narrow formats on the way out and keeps sticky CSR flags.
module fpnew_divsqrt_retire_buffer
   import fpnew_pkg::*;
#(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TagWidth = 8,
   localparam int unsigned PW      = $clog2(DEPTH),
   localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [WIDTH-1:0]    in_result_i,
   input  status_t             in_status_i,
   input  fp_format_e          in_fmt_i,
   input  logic                in_ext_i,
   input  logic [TagWidth-1:0] in_tag_i,
   input  logic                flush_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [WIDTH-1:0]    out_result_o,
   output status_t             out_status_o,
   output logic [TagWidth-1:0] out_tag_o,
   input  logic                clear_flags_i,
   output status_t             flags_acc_o,
   output logic [CW-1:0]       count_o,
   output logic                busy_o
);

   localparam int unsigned EW = WIDTH + 9 + TagWidth;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   status_t          r_flags;

   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic [EW-1:0]    w_wdata;
   logic [EW-1:0]    w_rdata;
   logic [WIDTH-1:0] w_rres;
   fp_format_e       w_rfmt;
   logic             w_rext;
   int unsigned      w_fw;
   logic [WIDTH-1:0] w_box;

   assign w_full      = (r_count == FULL);
   assign in_ready_o  = ~w_full;
   assign out_valid_o = (r_count != '0);
   assign busy_o      = out_valid_o;
   assign count_o     = r_count;
   assign flags_acc_o = r_flags;

   assign w_push = in_valid_i & in_ready_o & ~flush_i;
   assign w_pop  = out_valid_o & out_ready_i & ~flush_i;

   assign w_wdata = {in_result_i, in_status_i, in_fmt_i,
                     in_ext_i, in_tag_i};

   fpnew_retire_fifo_mem #(
      .EW    (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (w_push),
      .waddr_i (r_wr_ptr),
      .wdata_i (w_wdata),
      .raddr_i (r_rd_ptr),
      .rdata_o (w_rdata)
   );

   assign out_tag_o    = w_rdata[TagWidth-1:0];
   assign w_rext       = w_rdata[TagWidth];
   assign w_rfmt       = fp_format_e'(w_rdata[TagWidth+3:TagWidth+1]);
   assign out_status_o = status_t'(w_rdata[TagWidth+8:TagWidth+4]);
   assign w_rres       = w_rdata[EW-1:TagWidth+9];
   assign w_fw         = fp_width(w_rfmt);

   // Bits at or above the format width follow the extension bit.
   always_comb begin
      w_box = w_rres;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i >= w_fw) w_box[i] = w_rext;
      end
   end

   assign out_result_o = w_box;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_flags  <= '0;
      end else begin
         if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
         end
         if (clear_flags_i)
            r_flags <= w_pop ? out_status_o : '0;
         else if (w_pop)
            r_flags <= r_flags | out_status_o;
      end
   end

   a_no_push_full: assert property (@(posedge clk_i)
      disable iff (rst_i) !(w_push && w_full));

   a_count_max: assert property (@(posedge clk_i)
      disable iff (rst_i) r_count <= FULL);

   a_out_stable: assert property (@(posedge clk_i)
      disable iff (rst_i)
      (out_valid_o && !out_ready_i && !flush_i) |=>
      ($stable(out_result_o) && $stable(out_status_o) &&
       $stable(out_tag_o) && out_valid_o));

endmodule

// File: doc/fpnew_divsqrt_retire_buffer.md
Name: fpnew_divsqrt_retire_buffer

Overview:
- Sits directly downstream of the multi-cycle div/sqrt unit. Captures each completed result (value, status flags, tag, destination format) in a small FIFO so the unit never stalls on writeback back-pressure.
- NaN-boxes narrow-format results on the way out.
- Keeps a sticky accumulated-flags register for the FPU CSR path.

Parameters:
- WIDTH, 64, datapath width; must be at least the widest enabled format.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- TagWidth, 8, width of the tag carried with each result.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  result from the div/sqrt unit is valid
- in_ready_o  out  1  buffer can accept a result
- in_result_i  in  WIDTH  raw result, right-aligned
- in_status_i  in  5  status flags {NV,DZ,OF,UF,NX}
- in_fmt_i  in  3  fpnew_pkg::fp_format_e destination format
- in_ext_i  in  1  extension bit; 1 = NaN-box the result
- in_tag_i  in  TagWidth  operation tag
- flush_i  in  1  discard all buffered entries
- out_valid_o  out  1  head entry is valid
- out_ready_i  in  1  writeback accepts the head entry
- out_result_o  out  WIDTH  boxed result of the head entry
- out_status_o  out  5  status of the head entry
- out_tag_o  out  TagWidth  tag of the head entry
- clear_flags_i  in  1  clear the accumulated flags
- flags_acc_o  out  5  sticky OR of the status of all retired entries
- count_o  out  $clog2(DEPTH)+1  occupancy
- busy_o  out  1  at least one entry is held

Behaviour:
- Reset (rst_i high at a clock edge): pointers=0, count=0, flags_acc=0. in_ready_o=1, out_valid_o=0, busy_o=0, count_o=0. Storage array is not reset.
- Storage: DEPTH-entry array indexed by rd_ptr/wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Count is tracked separately so full (count==DEPTH) and empty (count==0) are unambiguous.
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & out_ready_i & ~flush_i.
- in_ready_o = (count != DEPTH). It is purely registered-state-derived, with no combinational path from out_ready_i. When full, a same-cycle pop does not enable a push.
- out_valid_o = (count != 0). Outputs are read combinationally from entry[rd_ptr], so an entry pushed at edge N is visible after edge N. Minimum latency is 1 cycle.
- Simultaneous push and pop (count neither 0 nor DEPTH): both pointers advance, count is unchanged.
- Push into an empty buffer: out_valid_o rises the next cycle; there is no same-cycle bypass.
- NaN-boxing, applied at the output from the stored fmt/ext:
  - If ext=1: all bits at or above the format width are forced to 1. Widths: FP32=32, FP64=64, FP16=16, FP8=8, FP16ALT=16.
  - If ext=0: those upper bits are forced to 0.
  - Formats wider than WIDTH pass through unchanged.
- Flags accumulator:
  - On pop: flags_acc <= flags_acc | out_status_o.
  - clear_flags_i has priority: with clear and pop in the same cycle, flags_acc <= out_status_o of the popped entry.
  - Without a pop, clear sets flags_acc to 0.
  - Flags of flushed entries are never accumulated.
- Flush: at the next edge, count=0 and rd_ptr=wr_ptr=0; any same-cycle push or pop is ignored. flags_acc is untouched unless clear_flags_i is also high. out_valid_o and in_ready_o are not gated combinationally by flush_i.
- busy_o = (count != 0).
- rst_i mid-operation behaves like flush and additionally clears flags_acc.
- Assertions:
  - no push while count==DEPTH
  - count never exceeds DEPTH
  - out_* stable while out_valid_o & ~out_ready_i, unless flush

Decomposition:
- In fpnew_pkg: the fp_format_e width lookup (fp_width(fmt)) and the status_t struct. The module reuses both and defines none locally.
- One sub-module, fpnew_retire_fifo_mem: the DEPTH×entry register array with write-enable, write index and read index.
- Pointer, count and flag control live in the top module.

Test Plan:
- Reset, then push one FP32 result 0x3F800000 with ext=1, fmt=FP32, tag=5, status=5'b00001 -> one cycle later out_result_o=0xFFFFFFFF3F800000, out_tag_o=5, count_o=1. Pop -> flags_acc_o=5'b00001, busy_o=0.
- Hold out_ready_i=0 and push 4 entries (tags 1..4) -> in_ready_o=0 after the 4th push, count_o=4. Release out_ready_i -> tags drain in order 1,2,3,4, wrapping pointers correctly.
- Keep the buffer at count 2 with push and pop every cycle for 10 cycles -> count_o stays 2, output tags follow input order with 2-cycle lag.
- Push FP16 0x3C00 with ext=0 and fmt=FP16 -> out_result_o=0x0000000000003C00. Push FP8 0x38 with ext=1 -> out_result_o=0xFFFFFFFFFFFFFF38.
- Buffer 3 entries (status NV, DZ, OF), assert flush_i while also pushing -> next cycle count_o=0, out_valid_o=0, flags_acc_o unchanged, pushed entry dropped.
- Pop an entry with status NX while clear_flags_i=1 and flags_acc_o=5'b10000 -> flags_acc_o=5'b00001. Assert rst_i with 2 entries held -> count_o=0, flags_acc_o=0, in_ready_o=1.
